// File: rtl/i2s_mic_array.sv
// rtl/i2s_mic_array.sv - I2S master receiver for a microphone array with Avalon-MM registers
// Generates sck/ws, shifts in 2*NUM_SD channels per frame and snapshots them at frame end.
module i2s_mic_array #(
  parameter int NUM_SD   = 2,
  parameter int SAMPLE_W = 24,
  parameter int SCK_DIV  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        address,
  input  logic [31:0]       writedata,
  input  logic [NUM_SD-1:0] sd,
  output logic              sck,
  output logic              ws,
  output logic [31:0]       readdata,
  output logic              irq
);
  localparam int NCH   = 2 * NUM_SD;
  localparam int DIV_W = $clog2(SCK_DIV);

  logic [DIV_W-1:0]    r_div_cnt;
  logic [5:0]          r_bit_cnt;
  logic                r_sck;
  logic                r_enable;
  logic                r_irq_en;
  logic [NUM_SD-1:0]   r_sd_meta;
  logic [NUM_SD-1:0]   r_sd_sync;
  logic [SAMPLE_W-1:0] r_shift_l [NUM_SD];
  logic [SAMPLE_W-1:0] r_shift_r [NUM_SD];
  logic [SAMPLE_W-1:0] r_sample  [NCH];
  logic                r_valid;
  logic                r_overrun;
  logic [31:0]         r_frame_cnt;
  logic [31:0]         r_readdata;
  logic                r_irq;

  logic        w_rise;
  logic        w_fall;
  logic        w_frame_end;
  logic        w_slot_hit;
  logic        w_status_rd;
  logic        w_ctrl_wr;
  logic [31:0] w_slot;
  logic [31:0] w_rd_mux;
  logic [31:0] w_ext [NCH];
  logic        w_unused;

  assign w_rise      = r_enable && (r_div_cnt == DIV_W'(SCK_DIV / 2 - 1));
  assign w_fall      = r_enable && (r_div_cnt == DIV_W'(SCK_DIV - 1));
  assign w_frame_end = w_fall && (r_bit_cnt == 6'd63);
  // Slot 0 of each half-frame is the I2S one-bit delay; slots past SAMPLE_W are padding.
  assign w_slot      = {27'd0, r_bit_cnt[4:0]};
  assign w_slot_hit  = w_rise && (w_slot >= 32'd1) && (w_slot <= 32'(SAMPLE_W));
  assign w_status_rd = chipselect && read && (address == 4'd8);
  assign w_ctrl_wr   = chipselect && write && (address == 4'd10);
  assign w_unused    = ^writedata[31:2];

  assign sck      = r_sck;
  assign ws       = r_bit_cnt[5];
  assign readdata = r_readdata;
  assign irq      = r_irq;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_enable  <= 1'b0;
      r_irq_en  <= 1'b0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= writedata[0];
        r_irq_en <= writedata[1];
      end
      if (!r_enable) begin
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_sck     <= 1'b0;
      end else begin
        r_div_cnt <= w_fall ? '0 : r_div_cnt + 1'b1;
        if (w_rise)      r_sck <= 1'b1;
        else if (w_fall) r_sck <= 1'b0;
        if (w_fall) r_bit_cnt <= r_bit_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sd_meta <= '0;
      r_sd_sync <= '0;
      for (int k = 0; k < NUM_SD; k++) begin
        r_shift_l[k] <= '0;
        r_shift_r[k] <= '0;
      end
      for (int c = 0; c < NCH; c++) r_sample[c] <= '0;
    end else begin
      r_sd_meta <= sd;
      r_sd_sync <= r_sd_meta;
      for (int k = 0; k < NUM_SD; k++) begin
        if (!r_enable) begin
          r_shift_l[k] <= '0;
          r_shift_r[k] <= '0;
        end else if (w_slot_hit && !r_bit_cnt[5]) begin
          r_shift_l[k] <= {r_shift_l[k][SAMPLE_W-2:0], r_sd_sync[k]};
        end else if (w_slot_hit) begin
          r_shift_r[k] <= {r_shift_r[k][SAMPLE_W-2:0], r_sd_sync[k]};
        end
        if (w_frame_end) begin
          r_sample[2*k]   <= r_shift_l[k];
          r_sample[2*k+1] <= r_shift_r[k];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) w_ext[c] = 32'($signed(r_sample[c]));
  end

  always_comb begin
    w_rd_mux = 32'd0;
    for (int c = 0; c < NCH; c++) begin
      if (address == 4'(c)) w_rd_mux = w_ext[c];
    end
    case (address)
      4'd8:    w_rd_mux = {30'd0, r_overrun, r_valid};
      4'd9:    w_rd_mux = r_frame_cnt;
      4'd10:   w_rd_mux = {30'd0, r_irq_en, r_enable};
      default: ;
    endcase
  end

  // A frame end in the same cycle as a STATUS read wins for valid and leaves overrun clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
      r_irq       <= 1'b0;
      r_readdata  <= '0;
    end else begin
      if (w_frame_end)      r_valid <= 1'b1;
      else if (w_status_rd) r_valid <= 1'b0;
      if (w_status_rd)                  r_overrun <= 1'b0;
      else if (w_frame_end && r_valid)  r_overrun <= 1'b1;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 32'd1;
      r_irq <= r_irq_en && r_valid;
      if (chipselect && read) r_readdata <= w_rd_mux;
    end
  end

endmodule

// File: tb/tb_i2s_mic_array.sv
// tb/tb_i2s_mic_array.sv - self-checking bench for i2s_mic_array
// An I2S microphone model drives sd by slot; expectations come from per-frame sample tables.
module tb_i2s_mic_array;
  localparam int NUM_SD   = 2;
  localparam int SAMPLE_W = 24;
  localparam int SCK_DIV  = 16;
  localparam int NCH      = 2 * NUM_SD;
  localparam int FRAME    = 64 * SCK_DIV;
  localparam logic [31:0] SMASK = 32'hFFFF_FFFF >> (32 - SAMPLE_W);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              chipselect = 1'b0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [3:0]        address = 4'd0;
  logic [31:0]       writedata = 32'd0;
  logic [NUM_SD-1:0] sd = '0;
  logic              sck;
  logic              ws;
  logic [31:0]       readdata;
  logic              irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int restart_id = 0;

  logic [31:0] tx_l [4][NUM_SD];
  logic [31:0] tx_r [4][NUM_SD];

  i2s_mic_array #(.NUM_SD(NUM_SD), .SAMPLE_W(SAMPLE_W), .SCK_DIV(SCK_DIV)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .sd(sd), .sck(sck), .ws(ws),
    .readdata(readdata), .irq(irq)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Microphone model: after the n-th falling sck of a frame it presents bit slot n.
  int   m_slot = 0;
  int   m_fidx = 0;
  int   m_seen = 0;
  logic m_prev = 1'b0;
  always @(negedge clk) begin
    if (restart_id != m_seen) begin
      m_seen = restart_id;
      m_slot = 0;
      m_fidx = 0;
    end else if (m_prev && !sck) begin
      m_slot = (m_slot + 1) % 64;
      if (m_slot == 0) m_fidx = m_fidx + 1;
    end
    m_prev = sck;
    for (int k = 0; k < NUM_SD; k++) begin
      logic [31:0] w;
      if (m_slot >= 1 && m_slot <= SAMPLE_W) begin
        w = tx_l[m_fidx % 4][k];
        sd[k] = w[SAMPLE_W - m_slot];
      end else if (m_slot >= 33 && m_slot <= 32 + SAMPLE_W) begin
        w = tx_r[m_fidx % 4][k];
        sd[k] = w[SAMPLE_W - (m_slot - 32)];
      end else begin
        sd[k] = 1'b0;
      end
    end
  end

  function automatic logic [31:0] sext(input logic [31:0] v);
    if (v[SAMPLE_W-1]) return v | ~SMASK;
    return v & SMASK;
  endfunction

  function automatic logic [31:0] expect_ch(input int f, input int c);
    if (c % 2 == 0) return sext(tx_l[f][c/2]);
    return sext(tx_r[f][c/2]);
  endfunction

  task automatic randomize_frames();
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < NUM_SD; k++) begin
        tx_l[f][k] = $urandom() & SMASK;
        tx_r[f][k] = $urandom() & SMASK;
      end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d, output int e0);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_cyc(input int t);
    int guard = 0;
    while (cyc < t && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != t) begin
      n_tests++; n_fail++;
      $display("FAIL wait_cyc: reached %0d required %0d", cyc, t);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_tests++;
    if ({sck, ws, irq} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pins: sck/ws/irq %b required 000", {sck, ws, irq});
    end
    for (int a = 0; a < 16; a++) begin
      reg_read(4'(a), d);
      n_tests++;
      if (d !== 32'd0) begin
        n_fail++; $display("FAIL reset_reg[%0d]: got %h required 0", a, d);
      end
    end
  endtask

  task automatic test_clocking();
    int e0;
    int r1 = -1, r2 = -1, f1 = -1, wr = -1, wf = -1;
    logic ps = 1'b0, pw = 1'b0;
    logic [31:0] d;
    do_reset();
    randomize_frames();
    restart_id++;
    reg_write(4'd10, 32'd1, e0);
    repeat (1100) begin
      @(negedge clk);
      if (sck && !ps) begin
        if (r1 < 0) r1 = cyc - e0;
        else if (r2 < 0) r2 = cyc - e0;
      end
      if (!sck && ps && f1 < 0) f1 = cyc - e0;
      if (ws && !pw && wr < 0) wr = cyc - e0;
      if (!ws && pw && wf < 0) wf = cyc - e0;
      ps = sck; pw = ws;
    end
    n_tests++;
    if (r1 != SCK_DIV / 2) begin n_fail++; $display("FAIL sck_first_rise: got %0d required %0d", r1, SCK_DIV / 2); end
    n_tests++;
    if (r2 - r1 != SCK_DIV) begin n_fail++; $display("FAIL sck_period: got %0d required %0d", r2 - r1, SCK_DIV); end
    n_tests++;
    if (f1 - r1 != SCK_DIV / 2) begin n_fail++; $display("FAIL sck_high: got %0d required %0d", f1 - r1, SCK_DIV / 2); end
    n_tests++;
    if (wr != 32 * SCK_DIV) begin n_fail++; $display("FAIL ws_first_rise: got %0d required %0d", wr, 32 * SCK_DIV); end
    n_tests++;
    if (wf - wr != 32 * SCK_DIV) begin n_fail++; $display("FAIL ws_half: got %0d required %0d", wf - wr, 32 * SCK_DIV); end
    reg_read(4'd9, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL clk_frame_cnt: got %h required 1", d); end
  endtask

  task automatic test_data();
    int e0;
    logic [31:0] d;
    do_reset();
    randomize_frames();
    tx_l[0][0] = 32'h80_0001;
    tx_r[0][0] = 32'h12_3456;
    tx_l[0][1] = 32'h00_0001;
    restart_id++;
    reg_write(4'd10, 32'd1, e0);
    wait_cyc(e0 + FRAME + 20);
    for (int c = 0; c < NCH; c++) begin
      reg_read(4'(c), d);
      n_tests++;
      if (d !== expect_ch(0, c)) begin n_fail++; $display("FAIL data_ch%0d: got %h required %h", c, d, expect_ch(0, c)); end
    end
    reg_read(4'd0, d);
    n_tests++;
    if (d !== 32'hFF80_0001) begin n_fail++; $display("FAIL data_sign_ext: got %h required ff800001", d); end
    reg_read(4'd8, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL data_status: got %h required 1", d); end
  endtask

  task automatic test_random_frames();
    int e0;
    logic [31:0] d;
    do_reset();
    randomize_frames();
    restart_id++;
    reg_write(4'd10, 32'd1, e0);
    for (int f = 0; f < 3; f++) begin
      wait_cyc(e0 + FRAME * (f + 1) + 30);
      for (int c = 0; c < NCH; c++) begin
        reg_read(4'(c), d);
        n_tests++;
        if (d !== expect_ch(f, c)) begin n_fail++; $display("FAIL rand_f%0d_ch%0d: got %h required %h", f, c, d, expect_ch(f, c)); end
      end
      reg_read(4'd8, d);
      n_tests++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL rand_status_f%0d: got %h required 1", f, d); end
      reg_read(4'd9, d);
      n_tests++;
      if (d !== 32'(f + 1)) begin n_fail++; $display("FAIL rand_frame_cnt: got %0d required %0d", d, f + 1); end
    end
    reg_read(4'(NCH), d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h required 0", d); end
  endtask

  task automatic test_irq();
    int e0;
    logic [31:0] d;
    do_reset();
    randomize_frames();
    restart_id++;
    reg_write(4'd10, 32'd3, e0);
    wait_cyc(e0 + FRAME - 5);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b required 0", irq); end
    wait_cyc(e0 + FRAME + 2);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b required 1", irq); end
    reg_read(4'd8, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL irq_status: got %h required 1", d); end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b required 1", irq); end
    @(negedge clk);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b required 0", irq); end
    reg_read(4'd10, d);
    n_tests++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL ctrl_readback: got %h required 3", d); end
  endtask

  task automatic test_overrun();
    int e0;
    logic [31:0] d;
    do_reset();
    randomize_frames();
    restart_id++;
    reg_write(4'd10, 32'd1, e0);
    wait_cyc(e0 + 2 * FRAME + 20);
    reg_read(4'd8, d);
    n_tests++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL ovr_status: got %h required 3", d); end
    reg_read(4'd9, d);
    n_tests++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL ovr_frame_cnt: got %0d required 2", d); end
    wait_cyc(e0 + 3 * FRAME - 1);
    reg_read(4'd8, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ovr_coincide_pre: got %h required 0", d); end
    reg_read(4'd8, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL ovr_coincide_post: got %h required 1", d); end
    wait_cyc(e0 + 5 * FRAME - 1);
    reg_read(4'd8, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL ovr_coincide2_pre: got %h required 1", d); end
    reg_read(4'd8, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL ovr_coincide2_post: got %h required 1", d); end
    reg_read(4'd9, d);
    n_tests++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL ovr_frame_cnt5: got %0d required 5", d); end
  endtask

  task automatic test_abort();
    int e0, e1, bad;
    logic [31:0] d;
    logic [31:0] keep [NCH];
    do_reset();
    randomize_frames();
    restart_id++;
    reg_write(4'd10, 32'd1, e0);
    wait_cyc(e0 + FRAME + 20);
    for (int c = 0; c < NCH; c++) keep[c] = expect_ch(0, c);
    reg_read(4'd8, d);
    wait_cyc(e0 + FRAME + 40 * SCK_DIV + 4);
    n_tests++;
    if (ws !== 1'b1) begin n_fail++; $display("FAIL abort_ws_before: got %b required 1", ws); end
    reg_write(4'd10, 32'd0, e1);
    repeat (4) @(negedge clk);
    bad = 0;
    repeat (64) begin
      @(negedge clk);
      if (sck !== 1'b0 || ws !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL abort_idle: %0d cycles with sck/ws high, required 0", bad); end
    wait_cyc(e0 + 2 * FRAME + 100);
    reg_read(4'd9, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL abort_frame_cnt: got %0d required 1", d); end
    reg_read(4'd8, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL abort_status: got %h required 0", d); end
    for (int c = 0; c < NCH; c++) begin
      reg_read(4'(c), d);
      n_tests++;
      if (d !== keep[c]) begin n_fail++; $display("FAIL abort_keep_ch%0d: got %h required %h", c, d, keep[c]); end
    end
    randomize_frames();
    restart_id++;
    repeat (2) @(negedge clk);
    reg_write(4'd10, 32'd1, e1);
    wait_cyc(e1 + FRAME + 20);
    for (int c = 0; c < NCH; c++) begin
      reg_read(4'(c), d);
      n_tests++;
      if (d !== expect_ch(0, c)) begin n_fail++; $display("FAIL restart_ch%0d: got %h required %h", c, d, expect_ch(0, c)); end
    end
    reg_read(4'd9, d);
    n_tests++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL restart_frame_cnt: got %0d required 2", d); end
    wait_cyc(e1 + FRAME + 20 * SCK_DIV + 4);
    do_reset();
    @(negedge clk);
    n_tests++;
    if ({sck, ws} !== 2'b00) begin n_fail++; $display("FAIL rst_abort_pins: got %b required 00", {sck, ws}); end
    wait_cyc(e1 + 2 * FRAME + 100);
    reg_read(4'd9, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL rst_abort_frame_cnt: got %0d required 0", d); end
    reg_read(4'd0, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL rst_abort_ch0: got %h required 0", d); end
    reg_read(4'd8, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL rst_abort_status: got %h required 0", d); end
  endtask

  initial begin
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < NUM_SD; k++) begin
        tx_l[f][k] = 32'd0;
        tx_r[f][k] = 32'd0;
      end
    @(negedge clk);
    test_reset();
    test_clocking();
    test_data();
    test_random_frames();
    test_irq();
    test_overrun();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
